// File: rtl/mem_arb_pkg.sv
// Shared types for the processor memory-port arbiter: FSM states and transaction owner.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } owner_t;

endpackage

// File: rtl/mem_arb_sel.sv
// Combinational winner selection between fetch and data requests.
// MEM_ARB_RR_EN switches contention handling from fixed dm priority to round-robin.
module mem_arb_sel
    import mem_arb_pkg::*;
(
    input  logic   if_req,
    input  logic   dm_req,
`ifdef MEM_ARB_RR_EN
    input  owner_t last_owner,
`endif
    output logic   any_req,
    output owner_t winner
);

    always_comb begin
        any_req = if_req | dm_req;
        winner  = OWN_DM;
        if (if_req && !dm_req) begin
            winner = OWN_IF;
        end
`ifdef MEM_ARB_RR_EN
        // On contention the side that was not granted last takes the port.
        if (if_req && dm_req && last_owner == OWN_DM) begin
            winner = OWN_IF;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the fetcher and the load/store stage, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin arbitration on contention; default is fixed dm priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int bits = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [bits-1:0]   if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [bits-1:0]   if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [bits/8-1:0] dm_be,
    input  logic [bits-1:0]   dm_addr,
    input  logic [bits-1:0]   dm_wdata,
    output logic              dm_gnt,
    output logic              dm_valid,
    output logic [bits-1:0]   dm_rdata,
    output logic              proc_req,
    output logic              we,
    output logic [bits/8-1:0] be,
    output logic [bits-1:0]   Add,
    output logic [bits-1:0]   Wdata,
    input  logic              mem_ready,
    input  logic              valid,
    input  logic [bits-1:0]   Rdata
);

    state_t            state, state_nxt;
    owner_t            owner_q;
    logic              we_q;
    logic [bits/8-1:0] be_q;
    logic [bits-1:0]   addr_q;
    logic [bits-1:0]   wdata_q;

    logic   any_req;
    owner_t winner;
    logic   load;
    logic   accept;
    logic   resp_hit;

`ifdef MEM_ARB_RR_EN
    owner_t last_owner;
`endif

    mem_arb_sel u_sel (
        .if_req     (if_req),
        .dm_req     (dm_req),
`ifdef MEM_ARB_RR_EN
        .last_owner (last_owner),
`endif
        .any_req    (any_req),
        .winner     (winner)
    );

    assign load     = (state == IDLE) && any_req;
    assign accept   = (state == REQ) && mem_ready;
    assign resp_hit = (state == RESP) && valid;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the request latches are reset too, so outputs derived from them are defined out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q <= OWN_IF;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (load) begin
            owner_q <= winner;
            if (winner == OWN_DM) begin
                we_q    <= dm_we;
                be_q    <= dm_be;
                addr_q  <= dm_addr;
                wdata_q <= dm_wdata;
            end else begin
                we_q    <= 1'b0;
                be_q    <= '0;
                addr_q  <= if_addr;
                wdata_q <= '0;
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    // Reset to OWN_IF so the first contended grant goes to dm.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner <= OWN_IF;
        end else if (accept) begin
            last_owner <= owner_q;
        end
    end
`endif

    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    always_comb begin
        state_nxt = state;
        proc_req  = 1'b0;
        we        = 1'b0;
        be        = '0;
        Add       = '0;
        Wdata     = '0;
        if_gnt    = 1'b0;
        dm_gnt    = 1'b0;
        if_valid  = 1'b0;
        dm_valid  = 1'b0;
        if_rdata  = '0;
        dm_rdata  = '0;

        case (state)
            IDLE: begin
                if (any_req) state_nxt = REQ;
            end
            REQ: begin
                proc_req = 1'b1;
                we       = we_q;
                be       = be_q;
                Add      = addr_q;
                Wdata    = wdata_q;
                if (accept) begin
                    if_gnt    = (owner_q == OWN_IF);
                    dm_gnt    = (owner_q == OWN_DM);
                    dm_valid  = (owner_q == OWN_DM) && we_q;
                    state_nxt = we_q ? IDLE : RESP;
                end
            end
            RESP: begin
                if (resp_hit) begin
                    if (owner_q == OWN_IF) begin
                        if_valid = 1'b1;
                        if_rdata = Rdata;
                    end else begin
                        dm_valid = 1'b1;
                        dm_rdata = Rdata;
                    end
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of arbitration order, grant timing and response routing.
module tb_mem_arbiter;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_valid;
    logic [31:0] dm_rdata;
    logic        proc_req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] Add;
    logic [31:0] Wdata;
    logic        mem_ready;
    logic        valid;
    logic [31:0] Rdata;

    int checks   = 0;
    int failures = 0;

    // Model state: pending requests and which side was granted last.
    logic if_pend;
    logic dm_pend;
    req_t if_r;
    req_t dm_r;
    logic last_was_dm;

    mem_arbiter #(.bits(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_valid  (if_valid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_be     (dm_be),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_valid  (dm_valid),
        .dm_rdata  (dm_rdata),
        .proc_req  (proc_req),
        .we        (we),
        .be        (be),
        .Add       (Add),
        .Wdata     (Wdata),
        .mem_ready (mem_ready),
        .valid     (valid),
        .Rdata     (Rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_if_gnt"},   {31'd0, if_gnt},   32'd0);
        check({tag, "_dm_gnt"},   {31'd0, dm_gnt},   32'd0);
        check({tag, "_if_valid"}, {31'd0, if_valid}, 32'd0);
        check({tag, "_dm_valid"}, {31'd0, dm_valid}, 32'd0);
        check({tag, "_if_rdata"}, if_rdata,          32'd0);
        check({tag, "_dm_rdata"}, dm_rdata,          32'd0);
    endtask

    task automatic drive_reqs();
        if_req   = if_pend;
        if_addr  = if_r.addr;
        dm_req   = dm_pend;
        dm_we    = dm_r.we;
        dm_be    = dm_r.be;
        dm_addr  = dm_r.addr;
        dm_wdata = dm_r.wdata;
    endtask

    function automatic req_t rand_req(input logic allow_store);
        req_t r;
        r.we    = allow_store ? 1'($urandom_range(0, 1)) : 1'b0;
        r.be    = 4'($urandom_range(1, 15));
        r.addr  = $urandom & 32'hFFFF_FFFC;
        r.wdata = $urandom;
        return r;
    endfunction

    // Winner rule: a lone requester wins; on contention dm wins, or under round-robin the side
    // not granted last wins.
    function automatic logic pick_dm();
        if (if_pend && !dm_pend) return 1'b0;
        if (dm_pend && !if_pend) return 1'b1;
`ifdef MEM_ARB_RR_EN
        return !last_was_dm;
`else
        return 1'b1;
`endif
    endfunction

    // Entered at the start of an IDLE cycle with at least one request pending and driven.
    task automatic run_txn(input int waits, input int lat, input logic [31:0] rd);
        logic        to_dm;
        logic        st;
        logic        fin;
        logic [31:0] ea;
        req_t        r;
        to_dm = pick_dm();
        r     = to_dm ? dm_r : if_r;
        st    = to_dm && r.we;
        ea    = r.addr;

        @(negedge clk);
        check("idle_proc_req", {31'd0, proc_req}, 32'd0);
        check_quiet("idle");
        step();

        for (int i = 0; i <= waits; i++) begin
            fin       = (i == waits);
            mem_ready = fin;
            valid     = 1'($urandom_range(0, 1));
            Rdata     = $urandom;
            @(negedge clk);
            check("req_proc_req", {31'd0, proc_req}, 32'd1);
            check("req_addr", Add, ea);
            check("req_we", {31'd0, we}, {31'd0, st});
            if (to_dm) check("req_be", {28'd0, be}, {28'd0, r.be});
            if (st) check("req_wdata", Wdata, r.wdata);
            check("req_if_gnt", {31'd0, if_gnt}, {31'd0, fin && !to_dm});
            check("req_dm_gnt", {31'd0, dm_gnt}, {31'd0, fin && to_dm});
            check("req_dm_valid", {31'd0, dm_valid}, {31'd0, fin && st});
            check("req_if_valid", {31'd0, if_valid}, 32'd0);
            check("req_if_rdata", if_rdata, 32'd0);
            check("req_dm_rdata", dm_rdata, 32'd0);
            step();
        end

        mem_ready   = 1'b0;
        valid       = 1'b0;
        last_was_dm = to_dm;
        if (to_dm) dm_pend = 1'b0;
        else       if_pend = 1'b0;
        drive_reqs();

        if (!st) begin
            for (int i = 0; i < lat; i++) begin
                mem_ready = 1'($urandom_range(0, 1));
                Rdata     = $urandom;
                @(negedge clk);
                check("wait_proc_req", {31'd0, proc_req}, 32'd0);
                check_quiet("wait");
                step();
            end
            mem_ready = 1'b0;
            valid     = 1'b1;
            Rdata     = rd;
            @(negedge clk);
            check("resp_proc_req", {31'd0, proc_req}, 32'd0);
            check("resp_if_valid", {31'd0, if_valid}, {31'd0, !to_dm});
            check("resp_dm_valid", {31'd0, dm_valid}, {31'd0, to_dm});
            check("resp_if_rdata", if_rdata, to_dm ? 32'd0 : rd);
            check("resp_dm_rdata", dm_rdata, to_dm ? rd : 32'd0);
            check("resp_if_gnt", {31'd0, if_gnt}, 32'd0);
            check("resp_dm_gnt", {31'd0, dm_gnt}, 32'd0);
            step();
            valid = 1'b0;
        end
    endtask

    initial begin
        rst         = 1'b0;
        mem_ready   = 1'b0;
        valid       = 1'b0;
        Rdata       = '0;
        if_pend     = 1'b0;
        dm_pend     = 1'b0;
        if_r        = '0;
        dm_r        = '0;
        last_was_dm = 1'b0;
        drive_reqs();

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_proc_req", {31'd0, proc_req}, 32'd0);
        check("rst_we", {31'd0, we}, 32'd0);
        check("rst_be", {28'd0, be}, 32'd0);
        check("rst_add", Add, 32'd0);
        check("rst_wdata", Wdata, 32'd0);
        check_quiet("rst");
        step();
        rst = 1'b1;

        // Fetch only.
        if_pend   = 1'b1;
        if_r      = '0;
        if_r.addr = 32'h100;
        drive_reqs();
        run_txn(0, 0, 32'h00A0_0093);

        // Store with two wait states.
        dm_pend = 1'b1;
        dm_r    = '{we: 1'b1, be: 4'hF, addr: 32'h2000, wdata: 32'hDEAD_BEEF};
        drive_reqs();
        run_txn(2, 0, 32'd0);

        // Contention between two loads.
        if_pend = 1'b1;
        if_r    = rand_req(1'b0);
        dm_pend = 1'b1;
        dm_r    = rand_req(1'b0);
`ifdef MEM_ARB_RR_EN
        for (int k = 0; k < 4; k++) begin
            if (!if_pend) begin if_pend = 1'b1; if_r = rand_req(1'b0); end
            if (!dm_pend) begin dm_pend = 1'b1; dm_r = rand_req(1'b0); end
            drive_reqs();
            run_txn(k % 2, 1, $urandom);
        end
`else
        for (int k = 0; k < 2; k++) begin
            drive_reqs();
            run_txn(k, 1, $urandom);
        end
`endif

        // Late data, then a spurious valid in IDLE.
        dm_pend = 1'b1;
        dm_r    = rand_req(1'b0);
        drive_reqs();
        run_txn(0, 5, 32'hCAFE_F00D);
        valid = 1'b1;
        Rdata = 32'h5555_AAAA;
        @(negedge clk);
        check("spur_proc_req", {31'd0, proc_req}, 32'd0);
        check_quiet("spur");
        step();
        valid = 1'b0;
        @(negedge clk);
        check("spur_after_proc_req", {31'd0, proc_req}, 32'd0);
        step();

        // Reset while waiting in RESP.
        dm_pend = 1'b1;
        dm_r    = rand_req(1'b0);
        drive_reqs();
        step();
        mem_ready = 1'b1;
        @(negedge clk);
        check("mid_dm_gnt", {31'd0, dm_gnt}, 32'd1);
        step();
        mem_ready = 1'b0;
        dm_pend   = 1'b0;
        drive_reqs();
        #2;
        valid = 1'b1;
        Rdata = 32'h1234_5678;
        rst   = 1'b0;
        #1;
        check("mid_rst_proc_req", {31'd0, proc_req}, 32'd0);
        check_quiet("mid_rst");
        step();
        rst         = 1'b1;
        last_was_dm = 1'b0;
        @(negedge clk);
        check("post_rst_proc_req", {31'd0, proc_req}, 32'd0);
        check_quiet("post_rst");
        step();
        valid     = 1'b0;
        if_pend   = 1'b1;
        if_r      = rand_req(1'b0);
        drive_reqs();
        run_txn(1, 2, $urandom);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            if (!if_pend && $urandom_range(0, 1) == 1) begin
                if_pend = 1'b1;
                if_r    = rand_req(1'b0);
            end
            if (!dm_pend && $urandom_range(0, 1) == 1) begin
                dm_pend = 1'b1;
                dm_r    = rand_req(1'b1);
            end
            if (!if_pend && !dm_pend) begin
                if_pend = 1'b1;
                if_r    = rand_req(1'b0);
            end
            drive_reqs();
            run_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
